// File: rtl/serial_pkg.sv
// Shared types and frame constants for the serial transmit path.
// Frame: start 0, 8 data bits MSB first, odd parity, stop 1.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP
  } state_t;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/serial_rr_arb.sv
// Combinational round-robin picker; search starts at last_grant+1.
// SERIAL_TX_ARB_LOCK_EN adds lock_en/lock_id to pin the grant.
module serial_rr_arb
  import serial_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       enable,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
`ifdef SERIAL_TX_ARB_LOCK_EN
  input  logic                       lock_en,
  input  logic [$clog2(NUM_REQ)-1:0] lock_id,
`endif
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] id
);

  localparam int IDW = $clog2(NUM_REQ);

  logic decided;
  int   idx;

  // First valid requester after last_grant wins, unless locked
  always_comb begin
    grant   = '0;
    id      = '0;
    decided = 1'b0;
    idx     = 0;
`ifdef SERIAL_TX_ARB_LOCK_EN
    if (lock_en) begin
      decided        = 1'b1;
      grant[lock_id] = enable & req[lock_id];
      id             = lock_id;
    end
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (enable && !decided && req[idx]) begin
        decided    = 1'b1;
        grant[idx] = 1'b1;
        id         = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/serial_tx_arb.sv
// Round-robin transmit arbiter and serial framer.
// Optional SERIAL_TX_ARB_LOCK_EN: req_lock pins arbitration.
module serial_tx_arb
  import serial_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
`ifdef SERIAL_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_lock,
`endif
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDW = $clog2(NUM_REQ);

  state_t         state, state_n;
  logic [7:0]     sh;
  logic           par;
  logic [2:0]     cnt;
  logic [3:0]     gcnt;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] arb_id;
  logic [7:0]     sel_byte;
  logic           tx_n;
  logic           hs;
`ifdef SERIAL_TX_ARB_LOCK_EN
  logic           lock_q;
`endif

  serial_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .enable     ((state == IDLE) && !reset),
    .last_grant (last_grant),
`ifdef SERIAL_TX_ARB_LOCK_EN
    .lock_en    (lock_q),
    .lock_id    (last_grant),
`endif
    .grant      (req_ready),
    .id         (arb_id)
  );

  assign hs       = |req_ready;
  assign sel_byte = req_data[{arb_id, 3'b000} +: 8];
  assign busy     = (state != IDLE);

  // Next state and next tx level; tx is registered from tx_n
  always_comb begin
    state_n = state;
    tx_n    = STOP_BIT;
    unique case (state)
      IDLE: begin
        if (hs) begin
          state_n = START;
          tx_n    = START_BIT;
        end
      end
      START: begin
        state_n = DATA;
        tx_n    = sh[7];
      end
      DATA: begin
        if (cnt == 3'(FRAME_DATA_BITS - 1)) begin
          state_n = PARITY;
          tx_n    = par;
        end else begin
          tx_n = sh[7];
        end
      end
      PARITY: state_n = STOP;
      STOP:   state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP: begin
        if (int'(gcnt) >= GAP_CYCLES - 1) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and serial line
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx    <= STOP_BIT;
    end else begin
      state <= state_n;
      tx    <= tx_n;
    end
  end

  // Byte capture, shifting, counters and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      sh         <= '0;
      par        <= 1'b0;
      cnt        <= '0;
      gcnt       <= '0;
      grant_id   <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
`ifdef SERIAL_TX_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      if (hs) begin
        sh         <= sel_byte;
        par        <= odd_parity(sel_byte);
        grant_id   <= arb_id;
        last_grant <= arb_id;
`ifdef SERIAL_TX_ARB_LOCK_EN
        lock_q     <= req_lock[arb_id];
`endif
      end else if (state_n == DATA) begin
        sh <= {sh[6:0], 1'b0};
      end
      cnt  <= (state == DATA) ? cnt + 3'd1 : 3'd0;
      gcnt <= (state == GAP) ? gcnt + 4'd1 : 4'd0;
    end
  end

endmodule

// File: tb/tb_serial_tx_arb.sv
// Randomized bench for serial_tx_arb against a frame-queue model.
// Handles SERIAL_TX_ARB_LOCK_EN builds as well as the default.
module tb_serial_tx_arb;

  localparam int N   = 4;
  localparam int G   = 1;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_lock = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           tx;
  logic           busy;
  logic [IDW-1:0] grant_id;

  always #5 clk = ~clk;

  serial_tx_arb #(.NUM_REQ(N), .GAP_CYCLES(G)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef SERIAL_TX_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: pending line bits of the frame in flight
  logic       q[$];
  logic [7:0] sent[$];
  logic       hist[$];
  int         hs_id[$];
  int         hs_t[$];
  int         m_last = N - 1;
  bit         m_lock = 0;
  int         m_gid = 0;
  int         cyc = 0;
  int         rx_n = -1;
  logic [7:0] rx_b;
  logic       rx_p;

  function automatic int pick_rr(input logic [N-1:0] v);
    if (m_lock) return v[m_last] ? m_last : -1;
    for (int k = 1; k <= N; k++)
      if (v[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  // loopback receiver: rebuild the byte from the line
  task automatic rx_sample(input logic b);
    if (rx_n < 0) begin
      if (b === 1'b0) rx_n = 0;
    end else if (rx_n < 8) begin
      rx_b = {rx_b[6:0], b};
      rx_n++;
    end else if (rx_n == 8) begin
      rx_p = b;
      rx_n++;
    end else begin
      chk("rx_stop", b, 1);
      chk("rx_parity", $countones({rx_b, rx_p}) % 2, 1);
      if (sent.size() != 0) chk("rx_byte", rx_b, sent.pop_front());
      else chk("rx_unexpected", rx_b, 32'hffff_ffff);
      rx_n = -1;
    end
  endtask

  task automatic step(input logic rst, input logic [N-1:0] v,
                      input logic [N*8-1:0] d, input logic [N-1:0] lk);
    int pick;
    logic [7:0] b;
    @(negedge clk);
    reset = rst;
    req_valid = v;
    req_data = d;
    req_lock = lk;
    #1;
    pick = (rst || q.size() != 0) ? -1 : pick_rr(v);
    chk("tx", tx, (q.size() != 0) ? q[0] : 1'b1);
    chk("busy", busy, q.size() != 0);
    chk("ready", req_ready, (pick < 0) ? 0 : (1 << pick));
    if (q.size() != 0) chk("grant_id", grant_id, m_gid);
    for (int i = 0; i < N; i++)
      if (req_ready[i] && req_valid[i]) begin
        hs_id.push_back(i);
        hs_t.push_back(cyc);
      end
    hist.push_back(tx);
    rx_sample(tx);
    if (rst) begin
      q.delete();
      sent.delete();
      m_last = N - 1;
      m_lock = 0;
      rx_n = -1;
    end else if (q.size() != 0) begin
      void'(q.pop_front());
    end else if (pick >= 0) begin
      b = d[pick*8 +: 8];
      q.push_back(1'b0);
      for (int i = 7; i >= 0; i--) q.push_back(b[i]);
      q.push_back(($countones(b) % 2) == 0);
      q.push_back(1'b1);
      repeat (G) q.push_back(1'b1);
      m_gid = pick;
      m_last = pick;
      sent.push_back(b);
`ifdef SERIAL_TX_ARB_LOCK_EN
      m_lock = lk[pick];
`endif
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, '0);
  endtask

  task automatic send(input int id, input logic [7:0] b, output int t);
    logic [N*8-1:0] d;
    int n0;
    d = '0;
    d[id*8 +: 8] = b;
    n0 = hs_id.size();
    t = -1;
    for (int k = 0; k < 30 && hs_id.size() == n0; k++)
      step(1'b0, N'(1 << id), d, '0);
    if (hs_id.size() == n0) begin
      chk("send_timeout", 0, 1);
    end else begin
      chk("send_id", hs_id[n0], id);
      t = hs_t[n0];
    end
    idle(13);
  endtask

`ifdef SERIAL_TX_ARB_LOCK_EN
  localparam int K = 4;
  int exp_lk[K] = '{1, 1, 1, 2};
`else
  localparam int K = 3;
  int exp_lk[K] = '{1, 2, 0};
`endif

  initial begin
    int t, n0, n1, prev, t_rst;
    logic [10:0] w;
    logic [N*8-1:0] rd;

    // reset with every requester valid
    repeat (3) step(1'b1, '1, 32'h44332211, '0);
    step(1'b0, '1, 32'h44332211, '0);
    chk("first_ready", req_ready, 4'b0001);
    idle(13);

    // 0xA5 from requester 0
    send(0, 8'hA5, t);
    if (t >= 0) begin
      w = '0;
      for (int k = 1; k <= 11; k++) w = {w[9:0], hist[t+k]};
      chk("a5_frame", w, 11'b01010010111);
    end

    // parity corner bytes
    send(1, 8'h00, t);
    if (t >= 0) chk("par_00", hist[t+10], 1);
    send(2, 8'h07, t);
    if (t >= 0) chk("par_07", hist[t+10], 0);
    send(3, 8'hFF, t);
    if (t >= 0) chk("par_ff", hist[t+10], 1);

    // continuous demand from all four
    n0 = hs_id.size();
    for (int k = 0; k < 60; k++) step(1'b0, '1, $urandom, '0);
    idle(14);
    if (hs_id.size() - n0 < 5) chk("rr_count", hs_id.size() - n0, 5);
    else
      for (int k = 0; k < 5; k++) begin
        chk("rr_order", hs_id[n0+k], k % 4);
        if (k > 0) chk("rr_period", hs_t[n0+k] - hs_t[n0+k-1], 12 + G);
      end

    // reset during data bit 3 of a frame from requester 2
    n0 = hs_id.size();
    for (int k = 0; k < 30 && hs_id.size() == n0; k++)
      step(1'b0, 4'b0100, 32'h00C30000, '0);
    repeat (5) step(1'b0, 4'b0000, '0, '0);
    t_rst = cyc;
    step(1'b1, 4'b0101, $urandom, '0);
    n0 = hs_id.size();
    for (int k = 0; k < 30 && hs_id.size() == n0; k++)
      step(1'b0, 4'b0101, $urandom, '0);
    chk("rst_tx", hist[t_rst+1], 1);
    if (hs_id.size() == n0) chk("rst_grant_timeout", 0, 1);
    else chk("rst_grant", hs_id[n0], 0);
    idle(13);

    // requester 1 sends three bytes with lock 1,1,0
    n0 = hs_id.size();
    n1 = 0;
    for (int k = 0; k < 80 && hs_id.size() - n0 < K; k++) begin
      prev = hs_id.size();
      step(1'b0, (n1 < 3) ? 4'b0111 : 4'b0101, $urandom,
           (n1 < 2) ? 4'b0010 : 4'b0000);
      if (hs_id.size() > prev && hs_id[prev] == 1) n1++;
    end
    idle(14);
    if (hs_id.size() - n0 < K) chk("lock_count", hs_id.size() - n0, K);
    else for (int k = 0; k < K; k++) chk("lock_order", hs_id[n0+k], exp_lk[k]);

    // random traffic with occasional reset
    for (int k = 0; k < 3000; k++) begin
      rd = {$urandom, $urandom} ;
      step($urandom_range(0, 199) == 0, N'($urandom), rd[N*8-1:0],
           N'($urandom));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tx_arb.md
# serial_tx_arb

Round-robin transmit arbiter and framer that shares one serial line among NUM_REQ byte sources. It grants one requester at a time with a valid/ready handshake, then serializes the captured byte in the team's frame format: start 0, 8 data bits MSB first, odd parity, stop 1. The frame matches what the serialDP receiver accepts, so a loopback of tx into serialDP.in yields done with the same byte.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- GAP_CYCLES, 1: extra tx=1 cycles after the stop bit, 0..15.

- clk  in  1  single clock, posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  requester i has a byte.
- req_data  in  NUM_REQ*8  byte of requester i in bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot; byte of requester i is accepted on a clk edge where valid[i] and ready[i] are both high.
- tx  out  1  serial line; idles high; registered.
- busy  out  1  high while a frame or gap is in progress.
- grant_id  out  $clog2(NUM_REQ)  index of the requester being sent; valid while busy.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, GAP.
- IDLE: the round-robin search starts at last_grant+1 and wraps. req_ready is high only for the first valid requester found, and only in IDLE.
- On a handshake: capture the byte into the shift register, compute parity = ~^byte, set grant_id, update last_grant, go to START.
- No valid requester: stay in IDLE.
- START: 1 cycle, then DATA.
- DATA: sends bit 7 first. A 3-bit counter runs 0..7 and the state moves to PARITY when the counter reaches 7.
- PARITY: 1 cycle, then STOP.
- STOP: 1 cycle, then GAP if GAP_CYCLES>0, else IDLE.
- GAP: counts GAP_CYCLES cycles, then IDLE.
- tx per state: 1 in IDLE, STOP and GAP; 0 in START; the current data bit in DATA; the parity bit in PARITY. Data bits plus the parity bit always contain an odd number of ones.
- req_data is sampled only at the handshake edge. Later changes on req_data do not affect the frame in progress.
- A requester that drops valid is skipped. The round-robin pointer still advances past the last granted index.

## Timing
- Reset values: tx=1, req_ready=0, busy=0, grant_id=0, last_grant=NUM_REQ-1 (requester 0 wins first), state IDLE.
- Handshake at edge E0, then:
  - cycle 1: start bit;
  - cycles 2..9: data bits d7..d0;
  - cycle 10: parity bit;
  - cycle 11: stop bit;
  - GAP_CYCLES gap cycles;
  - then one IDLE cycle in which the next handshake can occur.
- Handshake period is 12+GAP_CYCLES cycles under continuous demand.
- req_ready is combinational from state, req_valid and last_grant. It has no combinational path from tx.
- Reset mid-frame:
  - tx=1 in the first cycle after the reset edge and the frame is abandoned;
  - the accepted byte is lost, with no re-send;
  - last_grant returns to its reset value.
- Reset asserted during a handshake edge: no byte is accepted.

## Configuration
- SERIAL_TX_ARB_LOCK_EN defined:
  - Adds input req_lock [NUM_REQ].
  - If req_lock[i] is high at requester i's handshake, the next arbitration considers only requester i. Others wait, even if i has no valid byte.
  - This continues until requester i completes a handshake with req_lock[i]=0.
  - Reset clears the lock.
- Macro undefined: no req_lock port; pure round-robin.

## Structure
- Shared package serial_pkg holds:
  - state_t enum;
  - constants FRAME_DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1;
  - function odd_parity(byte), returning ~^byte.
- Sub-module serial_rr_arb handles arbitration.
  - Inputs: req, enable, last_grant, plus lock_en/lock_id when the macro is defined.
  - Outputs: one-hot grant and the encoded id.
  - It is purely combinational. The pointer lives in serial_tx_arb.

## Test plan
- Reset held 3 cycles, all valids high:
  - during reset and after it: tx=1, busy=0, req_ready=0;
  - first cycle after reset: req_ready=4'b0001.
- Requester 0 sends 0xA5, GAP_CYCLES=1:
  - tx over cycles 1..11 = 0,1,0,1,0,0,1,0,1,1,1;
  - loopback serialDP asserts done with out_byte=0xA5.
- Parity edge cases:
  - 0x00 sends parity 1;
  - 0x07 sends parity 0;
  - 0xFF sends parity 1;
  - loopback done asserted for each.
- All four requesters valid continuously:
  - grant order 0,1,2,3,0;
  - handshakes exactly 13 cycles apart with GAP_CYCLES=1.
- Reset asserted during data bit 3 of a frame from requester 2:
  - tx=1 the next cycle;
  - with requesters 0 and 2 still valid, the first grant after reset goes to requester 0.
- With SERIAL_TX_ARB_LOCK_EN, requester 1 sends 3 bytes with lock=1,1,0 while requesters 0 and 2 are valid:
  - grants are 1,1,1,2.
  - Without the macro, the same stimulus gives 1,2,0.
